priority_encoder_16x4: RTL and testbench
========================================

# priority_encoder_16x4

Registered 16-to-4 priority encoder with sticky request capture and a valid/ready output handshake. It is the encoding counterpart of the 4x16 decoder: it collects one-hot or multi-hot request lines, latches them as pending, and emits one 4-bit index per accepted transfer, highest index first. Downstream logic can feed the emitted index straight back into the decoder to regenerate a one-hot acknowledge.

## Interface
Parameters: none. Widths are fixed at 16 requests and a 4-bit code.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  16  request lines, sampled as levels every edge; bit i set raises pending[i]
- `clr`  in  1  synchronous clear of all pending requests and the output slot
- `ready`  in  1  consumer accepts `code` when `valid && ready` at an edge
- `code`  out  4  encoded index of the presented request; meaningful only while `valid`=1
- `valid`  out  1  output slot holds a request
- `pending`  out  16  current pending register, including the bit being presented
- `overflow`  out  1  one-cycle pulse: a request hit an already-pending bit

## Operation
- State: `pending[15:0]`, output slot (`valid`, `code`), `overflow` register.
- accept = `valid && ready`. clear_mask = accept ? onehot(`code`) : 0.
- Pending update: pending_nxt = (pending & ~clear_mask) | req. When set and clear hit the same bit in one cycle, set wins and the bit stays pending.
- Output slot loads only when it is empty (`valid`=0) or accepting:
  - `valid` <= |(pending & ~clear_mask)
  - `code` <= index of the highest set bit of (pending & ~clear_mask)
  - Bits arriving on `req` this cycle are not visible to the load.
- No preemption. While `valid`=1 and `ready`=0, `code` holds stable, even if a higher-index request arrives.
- No double issue. The presented bit stays in `pending` until accepted. The slot cannot reload while it is full.
- overflow_nxt = |(req & pending & ~clear_mask) and !`clr`. A repeated request on an un-accepted bit is merged, and is issued once.
- `clr`=1 overrides `req` and accept:
  - pending <= 0, `valid` <= 0, `code` <= 0, `overflow` <= 0.
  - A transfer presented during a `clr` cycle counts as not accepted.
- `rst_n`=0 asynchronously forces pending=0, `valid`=0, `code`=0, `overflow`=0, regardless of `clk`. Requests in flight are lost. The first capture happens at the first rising edge after deassertion.
- When `valid`=0, `code` holds its last loaded value, which is 0 after reset or `clr`.

## Timing
- Reset values: `code`=0, `valid`=0, `pending`=0, `overflow`=0.
- Request latency:
  - `req[i]` high at edge N sets `pending[i]` after N.
  - With an empty slot, `valid`=1 and `code`=i after edge N+1, a 2-cycle latency.
- Throughput: with `ready` held high, one index per cycle, back-to-back, in descending index order.
- Accept at edge M clears that pending bit after M. The next highest pending bit is presented after M with no bubble. If none is pending, `valid`=0 after M.
- `overflow` asserts the cycle after the colliding edge, for exactly one cycle per colliding edge.
- `pending` output reflects the register directly, with no extra latency.
- Boundary cases:
  - All 16 bits pending: issues codes 15 down to 0 over 16 accepting cycles.
  - Code 0 is valid and is distinguished from empty only by `valid`.

## Test plan
1. **Reset.** Hold `rst_n`=0 with `req`=16'hFFFF and toggle `clk`. Expect `pending`=0, `valid`=0, `code`=0, `overflow`=0. Release reset, drive `req`=0. Expect outputs to stay zero.
2. **Single request.** Pulse `req`=16'h0001 for 1 cycle with `ready`=1. Expect `pending`=16'h0001 after the first edge, then `valid`=1 and `code`=0 for one cycle, then `valid`=0 and `pending`=0.
3. **Priority order.** Pulse `req`=16'h8421 for 1 cycle with `ready`=1. Expect `code`=15, 10, 5, 0 on 4 consecutive cycles, then `valid`=0.
4. **Stall and no preemption.**
   - Pulse `req[3]` with `ready`=0. Expect `code`=3 to be presented.
   - Pulse `req[12]`. Expect `code` to stay 3 and `pending`=16'h1008.
   - Raise `ready`. Expect 3 to be accepted, then 12, then `valid`=0.
5. **Overflow and merging.**
   - Pulse `req[7]` with `ready`=0, then pulse `req[7]` again. Expect `overflow`=1 for one cycle.
   - Raise `ready`. Expect index 7 to be issued exactly once.
   - Repeat with `req[7]` high on the accepting edge. Expect no `overflow`, and 7 to be reissued.
6. **Clear and reset mid-operation.**
   - With `pending`=16'hF0F0, `valid`=1 and `ready`=1, assert `clr` together with `req`=16'h0001. Expect everything to read 0 next cycle, with no accept and no `overflow`.
   - Refill, then drop `rst_n` between edges. Expect outputs to go to 0 immediately.

Source files
------------

// File: rtl/priority_encoder_16x4.sv
// priority_encoder_16x4: registered 16-to-4 priority encoder with sticky request capture and valid/ready output
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [15:0] request levels, each set bit raises the matching pending bit
//   clr      in   synchronous clear of pending bits, output slot and overflow
//   ready    in   consumer takes code when valid && ready at an edge
//   code     out  [3:0] index of the presented request, meaningful while valid
//   valid    out  output slot holds a request
//   pending  out  [15:0] pending register, including the presented bit
//   overflow out  one-cycle pulse after a request hit an already-pending bit
module priority_encoder_16x4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        clr,
    input  logic        ready,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic        overflow
);
    logic [15:0] pending_q, pending_d, clear_mask, remain;
    logic [3:0]  code_q, code_d, top_idx;
    logic        valid_q, valid_d, overflow_q, overflow_d, accept, load;
    assign accept     = valid_q & ready;
    assign clear_mask = accept ? (16'd1 << code_q) : 16'd0;
    // Pending bits that survive this edge, before new requests are merged in;
    // the output slot only ever loads from these.
    assign remain     = pending_q & ~clear_mask;
    assign load       = ~valid_q | accept;
    always_comb begin
        top_idx = 4'd0;
        for (int i = 0; i < 16; i++)
            if (remain[i]) top_idx = 4'(i);
    end
    // Set wins over the accept clear, so a re-request on the accepting edge stays pending.
    always_comb begin
        pending_d  = clr ? 16'd0 : (remain | req);
        valid_d    = clr ? 1'b0 : (load ? |remain : valid_q);
        code_d     = clr ? 4'd0 : ((load && |remain) ? top_idx : code_q);
        overflow_d = ~clr & |(req & remain);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 16'd0;
            valid_q    <= 1'b0;
            code_q     <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end
    assign code     = code_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_priority_encoder_16x4.sv
// tb_priority_encoder_16x4: scoreboard bench for the registered 16-to-4 priority encoder
module tb_priority_encoder_16x4;
    logic        clk, rst_n, clr, ready;
    logic [15:0] req;
    logic [3:0]  code;
    logic        valid, overflow;
    logic [15:0] pending;
    int          errs, checks;
    logic [3:0]  exp_q[$];

    priority_encoder_16x4 dut (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .ready(ready),
        .code(code), .valid(valid), .pending(pending), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0 && !valid) break;
            tick();
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", valid, 0);
    endtask

    // A transfer is committed at the coming edge; compare it against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && valid && ready && !clr) begin
            logic [4:0] e;
            e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 5'd16;
            chk("issue_code", code, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errs = 0; checks = 0;
        rst_n = 0; req = 16'hFFFF; clr = 0; ready = 0;
        repeat (3) tick();
        chk("rst_pending", pending, 0);
        chk("rst_valid", valid, 0);
        chk("rst_code", code, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1; req = 0;
        tick(); tick();
        chk("idle_pending", pending, 0);
        chk("idle_valid", valid, 0);

        // single request, code 0
        ready = 1; req = 16'h0001; exp_q.push_back(0);
        tick();
        chk("single_pending", pending, 16'h0001);
        chk("single_valid_lat", valid, 0);
        req = 0;
        tick();
        chk("single_valid", valid, 1);
        chk("single_code", code, 0);
        tick();
        chk("single_done_valid", valid, 0);
        chk("single_done_pending", pending, 0);

        // priority order
        req = 16'h8421;
        foreach (exp_q[i]) ;
        exp_q.push_back(15); exp_q.push_back(10); exp_q.push_back(5); exp_q.push_back(0);
        tick();
        req = 0;
        drain();

        // stall and no preemption
        ready = 0; req = 16'h0008; exp_q.push_back(3);
        tick();
        req = 0;
        tick();
        chk("stall_code", code, 3);
        req = 16'h1000; exp_q.push_back(12);
        tick();
        chk("nopreempt_code", code, 3);
        chk("nopreempt_pending", pending, 16'h1008);
        req = 0;
        tick();
        chk("hold_code", code, 3);
        ready = 1;
        drain();

        // overflow and merging
        ready = 0; req = 16'h0080; exp_q.push_back(7);
        tick();
        chk("ovf_none_first", overflow, 0);
        req = 0;
        tick();
        req = 16'h0080;
        tick();
        chk("ovf_pulse", overflow, 1);
        req = 0;
        tick();
        chk("ovf_one_cycle", overflow, 0);
        ready = 1;
        drain();
        chk("merge_pending", pending, 0);

        // re-request on the accepting edge: no overflow, reissued
        ready = 0; req = 16'h0080; exp_q.push_back(7);
        tick();
        req = 0;
        tick();
        ready = 1; req = 16'h0080; exp_q.push_back(7);
        tick();
        chk("reacc_overflow", overflow, 0);
        chk("reacc_pending", pending, 16'h0080);
        chk("reacc_valid", valid, 0);
        req = 0;
        tick();
        chk("reissue_valid", valid, 1);
        drain();

        // all sixteen pending
        req = 16'hFFFF;
        for (int i = 15; i >= 0; i--) exp_q.push_back(4'(i));
        tick();
        chk("all_pending", pending, 16'hFFFF);
        req = 0;
        drain();

        // clear mid-operation
        ready = 0; req = 16'hF0F0;
        tick();
        req = 0;
        tick();
        chk("pre_clr_code", code, 15);
        ready = 1; clr = 1; req = 16'h0001;
        tick();
        chk("clr_pending", pending, 0);
        chk("clr_valid", valid, 0);
        chk("clr_code", code, 0);
        chk("clr_overflow", overflow, 0);
        clr = 0; req = 0; ready = 0;

        // asynchronous reset between edges
        req = 16'h00FF;
        tick();
        req = 0;
        tick();
        req = 16'h0080;
        tick();
        req = 0;
        chk("pre_rst_overflow", overflow, 1);
        chk("pre_rst_code", code, 7);
        #2 rst_n = 0;
        #1;
        chk("async_pending", pending, 0);
        chk("async_valid", valid, 0);
        chk("async_code", code, 0);
        chk("async_overflow", overflow, 0);
        tick();
        rst_n = 1;
        tick();
        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
